ldtu_gain_select: RTL and testbench

Gain-selection stage directly downstream of the baseline subtraction. It consumes the baseline-subtracted gain_10 and gain_1 samples and emits one 12-bit stream plus a gain flag. Gain_10 is the default. On gain_10 saturation the output switches to gain_1 for a window that also covers a programmable number of samples preceding the saturating sample, so pulses are never split across gains at their leading edge. Its output feeds the compression/encoding stage.

---
 rtl/ldtu_gs_pkg.sv | 33 +++
 rtl/ldtu_gain_select_if.sv | 24 ++
 rtl/ldtu_delay_line.sv | 27 ++
 rtl/ldtu_gain_select.sv | 86 ++++++++
 tb/tb_ldtu_gain_select.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ldtu_gs_pkg.sv
// Shared definitions for the LDTU gain-selection stage: mode encodings,
// gain flag encoding, window state names and default geometry.
package ldtu_gs_pkg;

    // GAIN_SEL_MODE encodings; both 0x codes select automatic switching.
    typedef enum logic [1:0] {
        AUTO0     = 2'b00,
        AUTO1     = 2'b01,
        FORCE_G10 = 2'b10,
        FORCE_G01 = 2'b11
    } gs_mode_e;

    // Meaning of the gain_sel output bit.
    typedef enum logic {
        GAIN_10 = 1'b0,
        GAIN_01 = 1'b1
    } gain_e;

    // Window state, G10 when the counter is idle, G01 while a window runs.
    typedef enum logic {
        ST_G10 = 1'b0,
        ST_G01 = 1'b1
    } gs_state_e;

    localparam int NBITS_DEFAULT = 12;
    localparam int PRE_DEFAULT   = 5;

    // Counter must hold PRE+16 (PRE+TIME_window+1 with TIME_window=15).
    function automatic int cnt_w_for(input int pre);
        return $clog2(pre + 17);
    endfunction

endpackage

// File: rtl/ldtu_gain_select_if.sv
// Sample/config bundle between baseline subtraction, gain selection and
// the encoder. master drives samples and config, slave is the selector.
interface ldtu_gain_select_if #(
    parameter int Nbits_12 = 12
);
    logic [Nbits_12-1:0] DATA_gain_01;
    logic [Nbits_12-1:0] DATA_gain_10;
    logic [Nbits_12-1:0] SATURATION_value;
    logic [3:0]          TIME_window;
    logic [1:0]          GAIN_SEL_MODE;
    logic [Nbits_12-1:0] DATA_gain_sel;
    logic                gain_sel;
    logic                sat_flag;

    modport master (
        output DATA_gain_01, DATA_gain_10, SATURATION_value, TIME_window, GAIN_SEL_MODE,
        input  DATA_gain_sel, gain_sel, sat_flag
    );

    modport slave (
        input  DATA_gain_01, DATA_gain_10, SATURATION_value, TIME_window, GAIN_SEL_MODE,
        output DATA_gain_sel, gain_sel, sat_flag
    );
endinterface

// File: rtl/ldtu_delay_line.sv
// Fixed-depth shift register with synchronous clear; holds the samples
// that may still be pulled into a gain_1 window retroactively.
module ldtu_delay_line #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5
) (
    input  logic             DCLK_1,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shift one sample per clock; clear empties the whole line.
    always_ff @(posedge DCLK_1) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/ldtu_gain_select.sv
// Gain selection: gain_10 by default, gain_1 for a window spanning PRE
// samples before a gain_10 saturation through TIME_window samples after.
// The PRE-deep delay lines let the window reach back before the trigger.
module ldtu_gain_select
    import ldtu_gs_pkg::*;
#(
    parameter int Nbits_12 = NBITS_DEFAULT,
    parameter int PRE      = PRE_DEFAULT,
    parameter int CNT_W    = cnt_w_for(PRE)
) (
    input logic                DCLK_1,
    input logic                rst,
    ldtu_gain_select_if.slave  bus
);

    gs_mode_e            mode;
    gs_state_e           state;
    logic                auto_mode;
    logic                sat_det;
    logic                sel_g01;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CNT_W-1:0]    cnt_load;
    logic [Nbits_12-1:0] tail_g01;
    logic [Nbits_12-1:0] tail_g10;
    logic [Nbits_12-1:0] data_sel_p1;
    gain_e               gain_sel_p1;
    logic                sat_flag_p1;

    ldtu_delay_line #(.WIDTH(Nbits_12), .DEPTH(PRE)) u_dl_g01 (
        .DCLK_1 (DCLK_1),
        .clr    (rst),
        .din    (bus.DATA_gain_01),
        .dout   (tail_g01)
    );

    ldtu_delay_line #(.WIDTH(Nbits_12), .DEPTH(PRE)) u_dl_g10 (
        .DCLK_1 (DCLK_1),
        .clr    (rst),
        .din    (bus.DATA_gain_10),
        .dout   (tail_g10)
    );

    assign mode      = gs_mode_e'(bus.GAIN_SEL_MODE);
    assign auto_mode = (mode == AUTO0) || (mode == AUTO1);
    // Saturation is judged on the undelayed sample; equality saturates.
    assign sat_det   = auto_mode && (bus.DATA_gain_10 >= bus.SATURATION_value);
    assign cnt_load  = CNT_W'(PRE + 1) + CNT_W'(bus.TIME_window);
    assign state     = (cnt == '0) ? ST_G10 : ST_G01;

    // Window counter next state: a new saturation always reloads, forced
    // modes drop any running window.
    always_comb begin
        cnt_nxt = cnt;
        if (!auto_mode)
            cnt_nxt = '0;
        else if (sat_det)
            cnt_nxt = cnt_load;
        else if (state == ST_G01)
            cnt_nxt = cnt - CNT_W'(1);
    end

    // Selecting on the next counter value lets the triggering cycle itself
    // already pick gain_1 for the sample PRE positions earlier.
    assign sel_g01 = (auto_mode && (cnt_nxt != '0)) || (mode == FORCE_G01);

    // Counter and registered outputs; sat_flag marks a 0->1 gain change in auto.
    always_ff @(posedge DCLK_1) begin
        if (rst) begin
            cnt         <= '0;
            data_sel_p1 <= '0;
            gain_sel_p1 <= GAIN_10;
            sat_flag_p1 <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            data_sel_p1 <= sel_g01 ? tail_g01 : tail_g10;
            gain_sel_p1 <= sel_g01 ? GAIN_01 : GAIN_10;
            sat_flag_p1 <= auto_mode && sel_g01 && (gain_sel_p1 == GAIN_10);
        end
    end

    assign bus.DATA_gain_sel = data_sel_p1;
    assign bus.gain_sel      = gain_sel_p1;
    assign bus.sat_flag      = sat_flag_p1;

endmodule

// File: tb/tb_ldtu_gain_select.sv
// Bench for ldtu_gain_select: scenario table plus mid-window mode-switch
// and reset sequences, every output sample checked against a queue model.
module tb_ldtu_gain_select;
    import ldtu_gs_pkg::*;

    localparam int PRE = 5;
    localparam int N   = 70;

    logic DCLK_1 = 1'b0;
    logic rst    = 1'b1;

    ldtu_gain_select_if bus ();

    ldtu_gain_select #(.Nbits_12(12), .PRE(PRE)) dut (
        .DCLK_1 (DCLK_1),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 DCLK_1 = ~DCLK_1;

    typedef struct {
        logic [11:0] g10;
        logic [11:0] g01;
        bit          win;
        bit          real_s;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] satv;
        logic [3:0]  tw;
        int          ka;
        logic [11:0] va;
        int          kb;
        logic [11:0] vb;
        int          exp_g1;
        int          exp_flags;
        int          exp_first;
    } scen_t;

    exp_t  exp_q[$];
    scen_t tbl[8];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    rem     = 0;
    bit    prev_gs = 1'b0;
    int    obs_g1, obs_flags, first_g1, first_one;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Model: a saturating sample marks itself and every queued (in-flight)
    // sample as gain_1, then the next TIME_window samples.
    task automatic model_push(input logic [11:0] g10v, input logic [11:0] g01v, input bit realv);
        exp_t r;
        exp_t tmp;
        r.g10 = g10v; r.g01 = g01v; r.real_s = realv; r.win = 1'b0;
        if (bus.GAIN_SEL_MODE[1]) begin
            rem = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                tmp = exp_q[i]; tmp.win = 1'b0; exp_q[i] = tmp;
            end
        end else if (g10v >= bus.SATURATION_value) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tmp = exp_q[i]; tmp.win = 1'b1; exp_q[i] = tmp;
            end
            r.win = 1'b1;
            rem = int'(bus.TIME_window);
        end else if (rem > 0) begin
            r.win = 1'b1;
            rem--;
        end
        exp_q.push_back(r);
    endtask

    task automatic pop_check();
        exp_t        r;
        bit          gs, fl;
        logic [11:0] d;
        r  = exp_q.pop_front();
        gs = (bus.GAIN_SEL_MODE == 2'b11) ? 1'b1 :
             (bus.GAIN_SEL_MODE == 2'b10) ? 1'b0 : r.win;
        fl = !bus.GAIN_SEL_MODE[1] && gs && !prev_gs;
        d  = gs ? r.g01 : r.g10;
        check("sample{data,gain_sel,sat_flag}",
              int'({bus.DATA_gain_sel, bus.gain_sel, bus.sat_flag}), int'({d, gs, fl}));
        prev_gs = gs;
        if (r.real_s) begin
            if (bus.gain_sel) begin
                obs_g1++;
                if (first_g1 < 0) first_g1 = int'(bus.DATA_gain_sel);
            end
            if (bus.sat_flag) obs_flags++;
        end
    endtask

    task automatic cycle(input logic [11:0] g10v, input logic [11:0] g01v, input bit realv);
        bus.DATA_gain_10 = g10v;
        bus.DATA_gain_01 = g01v;
        model_push(g10v, g01v, realv);
        @(posedge DCLK_1);
        @(negedge DCLK_1);
        if (exp_q.size() > PRE) pop_check();
    endtask

    task automatic do_reset(input int ncyc);
        exp_t z;
        rst = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            bus.DATA_gain_10 = 12'($urandom);
            bus.DATA_gain_01 = 12'($urandom);
            @(posedge DCLK_1);
            @(negedge DCLK_1);
            check("reset_outputs", int'({bus.DATA_gain_sel, bus.gain_sel, bus.sat_flag}), 0);
        end
        rst = 1'b0;
        exp_q.delete();
        z.g10 = '0; z.g01 = '0; z.win = 1'b0; z.real_s = 1'b0;
        for (int i = 0; i < PRE; i++) exp_q.push_back(z);
        rem = 0;
        prev_gs = 1'b0;
        obs_g1 = 0; obs_flags = 0; first_g1 = -1; first_one = -1;
    endtask

    initial begin
        logic [11:0] g10v;
        bit          done;

        tbl[0] = '{2'b00, 12'd4000, 4'd3,  20, 12'd4095, -1, 12'd0,    9,  1, 2063};
        tbl[1] = '{2'b00, 12'd4000, 4'd3,  20, 12'd4095, 22, 12'd4095, 11, 1, 2063};
        tbl[2] = '{2'b00, 12'd4000, 4'd3,  30, 12'd4000, 60, 12'd3999, 9,  1, 2073};
        tbl[3] = '{2'b11, 12'd4000, 4'd3,  20, 12'd4095, -1, 12'd0,    70, 0, 2048};
        tbl[4] = '{2'b10, 12'd4000, 4'd3,  20, 12'd4095, -1, 12'd0,    0,  0, -1};
        tbl[5] = '{2'b01, 12'd4000, 4'd0,  20, 12'd4095, -1, 12'd0,    6,  1, 2063};
        tbl[6] = '{2'b00, 12'd4000, 4'd15, 20, 12'd4095, -1, 12'd0,    21, 1, 2063};
        tbl[7] = '{2'b00, 12'd0,    4'd3,  -1, 12'd0,    -1, 12'd0,    70, 0, 2048};

        bus.GAIN_SEL_MODE    = 2'b00;
        bus.SATURATION_value = 12'd4000;
        bus.TIME_window      = 4'd3;
        bus.DATA_gain_10     = '0;
        bus.DATA_gain_01     = '0;
        @(negedge DCLK_1);

        for (int s = 0; s < 8; s++) begin
            bus.GAIN_SEL_MODE    = tbl[s].mode;
            bus.SATURATION_value = tbl[s].satv;
            bus.TIME_window      = tbl[s].tw;
            do_reset(3);
            for (int t = 0; t < N + PRE; t++) begin
                if (t < N) begin
                    g10v = (t == tbl[s].ka) ? tbl[s].va :
                           (t == tbl[s].kb) ? tbl[s].vb : 12'(t + 1);
                    cycle(g10v, 12'(2048 + t), 1'b1);
                end else begin
                    cycle(12'd0, 12'd0, 1'b0);
                end
                if (s == 0 && first_one < 0 && bus.DATA_gain_sel == 12'd1) first_one = t + 1;
            end
            if (s == 0) check("release_latency", first_one, PRE + 1);
            check($sformatf("scen%0d_gain1_count", s), obs_g1, tbl[s].exp_g1);
            check($sformatf("scen%0d_flag_count", s), obs_flags, tbl[s].exp_flags);
            check($sformatf("scen%0d_first_gain1", s), first_g1, tbl[s].exp_first);
        end

        // Auto -> force gain_10 after the third gain_1 output sample.
        bus.GAIN_SEL_MODE    = 2'b00;
        bus.SATURATION_value = 12'd4000;
        bus.TIME_window      = 4'd3;
        do_reset(2);
        done = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (!done && obs_g1 == 3) begin
                bus.GAIN_SEL_MODE = 2'b10;
                done = 1'b1;
            end
            cycle((t == 20) ? 12'd4095 : 12'(t + 1), 12'(2048 + t), 1'b1);
        end
        check("switch_gain1_count", obs_g1, 3);
        check("switch_flag_count", obs_flags, 1);

        // Reset on the third gain_1 output sample aborts the window.
        bus.GAIN_SEL_MODE = 2'b00;
        do_reset(2);
        done = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (!done && obs_g1 == 3) begin
                do_reset(1);
                obs_g1 = 3;
                done = 1'b1;
            end
            cycle((t == 20) ? 12'd4095 : 12'(t + 1), 12'(2048 + t), 1'b1);
        end
        check("midreset_gain1_count", obs_g1, 3);
        check("midreset_flag_count", obs_flags, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
